// File: rtl/gray_ptr_fifo_if.sv
// Handshake bundle between a gray_ptr_fifo and its producer/consumer.
// ovf_err/udf_err exist only when FIFO_ERR_FLAG_EN is defined.
interface gray_ptr_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
`ifdef FIFO_ERR_FLAG_EN
    logic              ovf_err;
    logic              udf_err;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, count, ovf_err, udf_err
    );
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, count, ovf_err, udf_err
    );
`else
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, count
    );
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, count
    );
`endif
endinterface

// File: rtl/gray_ptr_fifo.sv
// Single-clock FIFO with Gray-coded read/write pointers and a registered read port.
// Define FIFO_ERR_FLAG_EN to add sticky overflow/underflow flags.
module gray_ptr_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic           clck,
    input  logic           rst,
    gray_ptr_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = ADDR_W + 1;

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic [PTR_W-1:0]  wbin, rbin;
    logic [ADDR_W-1:0] waddr, raddr;
    logic              full, empty;
    logic              wr_ok, rd_ok;

    assign wbin  = gray2bin(wptr_q);
    assign rbin  = gray2bin(rptr_q);
    assign waddr = wbin[ADDR_W-1:0];
    assign raddr = rbin[ADDR_W-1:0];

    // Full: pointers a whole depth apart, which in Gray flips the top two bits.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q == {~rptr_q[ADDR_W:ADDR_W-1], rptr_q[ADDR_W-2:0]});

    assign wr_ok = bus.wr_en & ~full;
    assign rd_ok = bus.rd_en & ~empty;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (wr_ok) begin
            wptr_d = bin2gray(wbin + 1'b1);
        end
        if (rd_ok) begin
            rptr_d     = bin2gray(rbin + 1'b1);
            rd_data_d  = mem_q[raddr];
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clck) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is intentionally not reset; the pointers alone define validity.
    always_ff @(posedge clck) begin
        if (!rst && wr_ok) begin
            mem_q[waddr] <= bus.wr_data;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = wbin - rbin;

`ifdef FIFO_ERR_FLAG_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    assign ovf_d = ovf_q | (bus.wr_en & full);
    assign udf_d = udf_q | (bus.rd_en & empty);

    always_ff @(posedge clck) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.ovf_err = ovf_q;
    assign bus.udf_err = udf_q;
`else
    // Without the flags, dropped writes and ignored reads are silent.
`endif

endmodule

// File: tb/tb_gray_ptr_fifo.sv
// Directed scoreboard bench for gray_ptr_fifo; error flags are checked when FIFO_ERR_FLAG_EN is defined.
module tb_gray_ptr_fifo;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic clck = 1'b0;
    logic rst;

    gray_ptr_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    gray_ptr_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clck (clck),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clck = ~clck;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] sb [$];
    int                cnt_m;
    logic [DATA_W-1:0] last_rd_m;
    logic              ovf_m, udf_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
`ifdef FIFO_ERR_FLAG_EN
        chk({tag, ":ovf_err"}, 32'(bus.ovf_err), 32'(ovf_m));
        chk({tag, ":udf_err"}, 32'(bus.udf_err), 32'(udf_m));
`else
        chk({tag, ":rd_valid_idle"}, 32'(bus.rd_valid), 32'(1'b0));
`endif
    endtask

    // One clock: state checks before the edge, read-port checks after it.
    task automatic step(input logic we, input logic [DATA_W-1:0] wd, input logic re, input string tag);
        logic wok, rok;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        chk({tag, ":count"}, 32'(bus.count), 32'(cnt_m));
        chk({tag, ":empty"}, 32'(bus.empty), 32'(cnt_m == 0));
        chk({tag, ":full"},  32'(bus.full),  32'(cnt_m == DEPTH));
        wok = we && (cnt_m != DEPTH);
        rok = re && (cnt_m != 0);
        if (we && cnt_m == DEPTH) ovf_m = 1'b1;
        if (re && cnt_m == 0)     udf_m = 1'b1;
        if (wok) sb.push_back(wd);
        @(posedge clck);
        #1;
        if (rok) last_rd_m = sb.pop_front();
        cnt_m = cnt_m + int'(wok) - int'(rok);
        chk({tag, ":rd_valid"}, 32'(bus.rd_valid), 32'(rok));
        chk({tag, ":rd_data"},  32'(bus.rd_data),  32'(last_rd_m));
`ifdef FIFO_ERR_FLAG_EN
        chk({tag, ":ovf_err"}, 32'(bus.ovf_err), 32'(ovf_m));
        chk({tag, ":udf_err"}, 32'(bus.udf_err), 32'(udf_m));
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clck);
            #1;
        end
        rst       = 1'b0;
        cnt_m     = 0;
        last_rd_m = '0;
        ovf_m     = 1'b0;
        udf_m     = 1'b0;
        sb.delete();
    endtask

    initial begin
        logic [DATA_W-1:0] d;

        // 1. reset and idle
        do_reset(2);
        chk("reset:empty",    32'(bus.empty),    32'(1'b1));
        chk("reset:full",     32'(bus.full),     32'(1'b0));
        chk("reset:count",    32'(bus.count),    32'(0));
        chk("reset:rd_valid", 32'(bus.rd_valid), 32'(1'b0));
        chk("reset:rd_data",  32'(bus.rd_data),  32'(0));
        check_flags("reset");
        step(1'b0, 8'h00, 1'b0, "idle");

        // 2. fill with 0x11..0x88, then drain
        for (int i = 1; i <= 8; i++) begin
            d = 8'(i * 8'h11);
            step(1'b1, d, 1'b0, "fill");
        end
        chk("fill:full", 32'(bus.full), 32'(1'b1));

        // 3. write while full is dropped
        step(1'b1, 8'hFF, 1'b0, "ovf_drop");
        chk("ovf_drop:count", 32'(bus.count), 32'(8));
        step(1'b0, 8'h00, 1'b0, "ovf_hold");

        // 4a. simultaneous access when full: read oldest, drop write
        step(1'b1, 8'hEE, 1'b1, "full_rw");
        chk("full_rw:count", 32'(bus.count), 32'(7));
        chk("full_rw:oldest", 32'(bus.rd_data), 32'(8'h11));

        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, "drain");
        chk("drain:empty", 32'(bus.empty), 32'(1'b1));
        chk("drain:last",  32'(bus.rd_data), 32'(8'h88));

        // 4b. simultaneous access when empty: write only, no fall-through
        step(1'b1, 8'h5A, 1'b1, "empty_rw");
        chk("empty_rw:count",    32'(bus.count),    32'(1));
        chk("empty_rw:rd_valid", 32'(bus.rd_valid), 32'(1'b0));
        step(1'b0, 8'h00, 1'b1, "empty_rw_drain");
        step(1'b0, 8'h00, 1'b1, "udf_read");

        // 5. steady-state streaming at depth 3 across several pointer wraps
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, "pre");
        for (int i = 0; i < 40; i++) step(1'b1, 8'(i * 7 + 3), 1'b1, "stream");
        chk("stream:count", 32'(bus.count), 32'(3));

        // 6. mid-stream reset discards contents and clears flags
        for (int i = 0; i < 2; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, "load5");
        chk("load5:count", 32'(bus.count), 32'(5));
        do_reset(1);
        chk("midrst:count", 32'(bus.count), 32'(0));
        chk("midrst:empty", 32'(bus.empty), 32'(1'b1));
        check_flags("midrst");
        step(1'b1, 8'h3C, 1'b0, "post_wr");
        step(1'b0, 8'h00, 1'b1, "post_rd");
        chk("post_rd:data", 32'(bus.rd_data), 32'(8'h3C));
        step(1'b0, 8'h00, 1'b0, "post_idle");

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
